// File: rtl/aes_top.sv
// aes_top: iterative AES-128 encryption core, one round per clock, round keys expanded on the fly.
// Optional complementary output pair is built when AES_OUT_COMPLEMENT_EN is defined.
module aes_top (
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
`ifdef AES_OUT_COMPLEMENT_EN
    ,
    output logic [127:0] AES_data_out_complementary,
    output logic         AES_data_out_complementary_valid
`endif
);

    typedef enum logic {IDLE, RUN} fsm_t;

    // Entry 0 occupies the most significant byte of the packed table.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes and ShiftRows fused: output byte (row r, col c) takes input byte (r, (c+r) mod 4).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        int unsigned  src;
        o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            o[127 - 8*i -: 8] = sbox(s[127 - 8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    fsm_t         fsm;
    logic [3:0]   rnd;
    logic [127:0] state;
    logic [127:0] round_key;
    logic [127:0] shifted;
    logic [127:0] key_next;
    logic [127:0] round_out;

    always_comb begin
        shifted   = sub_shift(state);
        key_next  = next_key(round_key, rcon(rnd));
        round_out = ((rnd == 4'd10) ? shifted : mix_columns(shifted)) ^ key_next;
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            fsm                <= IDLE;
            rnd                <= '0;
            state              <= '0;
            round_key          <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
`ifdef AES_OUT_COMPLEMENT_EN
            AES_data_out_complementary       <= '0;
            AES_data_out_complementary_valid <= 1'b0;
`endif
        end else begin
            AES_data_out_valid <= 1'b0;
`ifdef AES_OUT_COMPLEMENT_EN
            AES_data_out_complementary_valid <= 1'b0;
`endif
            case (fsm)
                IDLE: begin
                    if (AES_en) begin
                        state     <= AES_data_in ^ AES_key_in;
                        round_key <= AES_key_in;
                        rnd       <= 4'd1;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    state     <= round_out;
                    round_key <= key_next;
                    if (rnd == 4'd10) begin
                        AES_data_out       <= round_out;
                        AES_data_out_valid <= 1'b1;
`ifdef AES_OUT_COMPLEMENT_EN
                        AES_data_out_complementary       <= ~round_out;
                        AES_data_out_complementary_valid <= 1'b1;
`endif
                        rnd <= '0;
                        fsm <= IDLE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_top.sv
// Directed bench for aes_top: known-answer vectors checked through an expected-result queue
// that also carries the edge number on which each valid pulse must appear.
module tb_aes_top;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] din;
    logic [127:0] key;
    logic [127:0] dout;
    logic         dout_valid;
`ifdef AES_OUT_COMPLEMENT_EN
    logic [127:0] dout_c;
    logic         dout_c_valid;
`endif

    aes_top dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (key),
        .AES_data_out       (dout),
        .AES_data_out_valid (dout_valid)
`ifdef AES_OUT_COMPLEMENT_EN
        ,
        .AES_data_out_complementary       (dout_c),
        .AES_data_out_complementary_valid (dout_c_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [127:0] last_out = '0;
    logic [127:0] exp_q[$];
    int           exp_cyc_q[$];

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Start request is sampled on the next edge (cyc+1); the pulse must follow 10 edges later.
    task automatic push_start(input logic [127:0] ct, input int start_edge);
        exp_q.push_back(ct);
        exp_cyc_q.push_back(start_edge + 10);
    endtask

    task automatic step();
        logic [127:0] e;
        int           ec;
        @(posedge clk);
        #1;
        cyc++;
`ifdef AES_OUT_COMPLEMENT_EN
        chk("comp_valid_timing", {127'b0, dout_c_valid}, {127'b0, dout_valid});
`endif
        if (dout_valid === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_valid observed=%h expected=no_pulse at_edge=%0d", dout, cyc);
            end
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("ciphertext", dout, e);
                chk("valid_edge", 128'(cyc), 128'(ec));
`ifdef AES_OUT_COMPLEMENT_EN
                chk("complement", dout_c, ~e);
`endif
            end
            last_out = dout;
        end else begin
            chk("out_stable", dout, last_out);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        key = '0;
        last_out = '0;
        steps(2);
        chk("reset_out", dout, '0);
        chk("reset_valid", {127'b0, dout_valid}, '0);

        // Idle with garbage on the data/key inputs must stay silent.
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            din = rnd128();
            key = rnd128();
            step();
        end
        chk("idle_out", dout, '0);

        // FIPS-197 C.1 with a single-cycle start pulse.
        en = 1'b1; din = C1_PT; key = C1_KEY;
        push_start(C1_CT, cyc + 1);
        step();
        en = 1'b0;
        steps(13);
        chk("c1_drained", 128'(exp_q.size()), '0);
        chk("c1_held", dout, C1_CT);

        // FIPS-197 App. B with inputs scrambled every cycle while the block is in flight.
        en = 1'b1; din = B_PT; key = B_KEY;
        push_start(B_CT, cyc + 1);
        step();
        en = 1'b0;
        for (int i = 0; i < 13; i++) begin
            din = rnd128();
            key = rnd128();
            step();
        end
        chk("b_drained", 128'(exp_q.size()), '0);

        // All-zero block with start held: new block every 11 edges.
        din = '0; key = '0; en = 1'b1;
        for (int k = 0; k < 5; k++) push_start(Z_CT, cyc + 1 + 11 * k);
        steps(50);
        en = 1'b0;
        steps(15);
        chk("zero_drained", 128'(exp_q.size()), '0);
        chk("zero_held", dout, Z_CT);

        // Reset in round 5 aborts the block without a pulse.
        en = 1'b1; din = C1_PT; key = C1_KEY;
        step();
        en = 1'b0;
        din = rnd128();
        steps(4);
        rst = 1'b1;
        last_out = '0;
        step();
        rst = 1'b0;
        chk("abort_out", dout, '0);
        chk("abort_valid", {127'b0, dout_valid}, '0);
        steps(15);
        chk("abort_quiet", dout, '0);

        // Sanity run after the abort.
        en = 1'b1; din = C1_PT; key = C1_KEY;
        push_start(C1_CT, cyc + 1);
        step();
        en = 1'b0;
        steps(13);
        chk("final_drained", 128'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
